// File: rtl/jump_control_sequencer.sv
// Hardwired fetch/decode/execute control FSM for the miniSRC datapath (jr, jal, nop).
// Optional in-port preload of Ra before jr/jal: define SEQ_INPORT_PRELOAD_EN.
module jump_control_sequencer #(
   parameter int unsigned     MEM_WAIT = 2,
   parameter int unsigned     OP_W     = 5,
   parameter logic [OP_W-1:0] OP_JR    = OP_W'(5'b10101),
   parameter logic [OP_W-1:0] OP_JAL   = OP_W'(5'b10110),
   parameter logic [OP_W-1:0] OP_NOP   = OP_W'(5'b11010),
   parameter logic [OP_W-1:0] OP_ADD   = OP_W'(5'b00011)
) (
   input  logic            clock,
   input  logic            clear,
   input  logic            run,
   input  logic [OP_W-1:0] ir_op,
   output logic            PCout_en,
   output logic            IncPC,
   output logic            PC_en,
   output logic            IR_en,
   output logic            MARin,
   output logic            MDRin,
   output logic            MDRout,
   output logic            memRead,
   output logic            Zin,
   output logic            Zlowout,
   output logic            Gra,
   output logic            Rin,
   output logic            Rout,
   output logic            jal_R15,
   output logic [OP_W-1:0] alu_op,
   output logic            busy,
   output logic            instr_done,
   output logic            unsupported
`ifdef SEQ_INPORT_PRELOAD_EN
   ,
   output logic            inPortOut
`endif
);

   localparam int unsigned CNT_W = (MEM_WAIT == 0) ? 1 : $clog2(MEM_WAIT + 1);

   localparam int unsigned S_PCOUT  = 0;
   localparam int unsigned S_INCPC  = 1;
   localparam int unsigned S_PCEN   = 2;
   localparam int unsigned S_IREN   = 3;
   localparam int unsigned S_MARIN  = 4;
   localparam int unsigned S_MDRIN  = 5;
   localparam int unsigned S_MDROUT = 6;
   localparam int unsigned S_MEMRD  = 7;
   localparam int unsigned S_ZIN    = 8;
   localparam int unsigned S_ZLOW   = 9;
   localparam int unsigned S_GRA    = 10;
   localparam int unsigned S_RIN    = 11;
   localparam int unsigned S_ROUT   = 12;
   localparam int unsigned S_JAL    = 13;
   localparam int unsigned S_BUSY   = 14;
   localparam int unsigned S_DONE   = 15;
   localparam int unsigned S_UNSUP  = 16;
   localparam int unsigned S_INPORT = 17;
`ifdef SEQ_INPORT_PRELOAD_EN
   localparam int unsigned NS = 18;
`else
   localparam int unsigned NS = 17;
`endif

   typedef enum logic [3:0] {
      ST_IDLE, ST_T0, ST_T1, ST_WAIT, ST_T2, ST_DECODE,
      ST_PRELOAD, ST_LINK, ST_JUMP, ST_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NS-1:0]   strb_q, strb_d;
   logic [OP_W-1:0] alu_q, alu_d;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         strb_q  <= '0;
         alu_q   <= OP_NOP;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         strb_q  <= strb_d;
         alu_q   <= alu_d;
      end
   end

   // Next state, then outputs registered from a decode of the next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      strb_d  = '0;
      alu_d   = OP_NOP;

      case (state_q)
         ST_IDLE:   if (run) state_d = ST_T0;
         ST_T0:     state_d = ST_T1;
         ST_T1: begin
            cnt_d   = CNT_W'(MEM_WAIT);
            state_d = (MEM_WAIT > 0) ? ST_WAIT : ST_T2;
         end
         ST_WAIT: begin
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = ST_T2;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_T2:     state_d = ST_DECODE;
         ST_DECODE: begin
`ifdef SEQ_INPORT_PRELOAD_EN
            if (ir_op == OP_JR || ir_op == OP_JAL) state_d = ST_PRELOAD;
            else                                  state_d = ST_DONE;
`else
            if (ir_op == OP_JR)       state_d = ST_JUMP;
            else if (ir_op == OP_JAL) state_d = ST_LINK;
            else                      state_d = ST_DONE;
`endif
         end
         ST_PRELOAD: state_d = (ir_op == OP_JAL) ? ST_LINK : ST_JUMP;
         ST_LINK:    state_d = ST_JUMP;
         ST_JUMP:    state_d = ST_DONE;
         ST_DONE:    state_d = run ? ST_T0 : ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      strb_d[S_BUSY] = (state_d != ST_IDLE);
      case (state_d)
         ST_T0: begin
            strb_d[S_PCOUT] = 1'b1;
            strb_d[S_MARIN] = 1'b1;
            strb_d[S_INCPC] = 1'b1;
            strb_d[S_ZIN]   = 1'b1;
            alu_d           = OP_ADD;
         end
         ST_T1: begin
            strb_d[S_ZLOW]  = 1'b1;
            strb_d[S_PCEN]  = 1'b1;
            strb_d[S_MEMRD] = 1'b1;
            strb_d[S_MDRIN] = 1'b1;
         end
         ST_WAIT: begin
            strb_d[S_MEMRD] = 1'b1;
            strb_d[S_MDRIN] = 1'b1;
         end
         ST_T2: begin
            strb_d[S_MDROUT] = 1'b1;
            strb_d[S_IREN]   = 1'b1;
         end
         ST_PRELOAD: begin
            strb_d[S_GRA] = 1'b1;
            strb_d[S_RIN] = 1'b1;
`ifdef SEQ_INPORT_PRELOAD_EN
            strb_d[S_INPORT] = 1'b1;
`endif
         end
         ST_LINK: begin
            strb_d[S_PCOUT] = 1'b1;
            strb_d[S_RIN]   = 1'b1;
            strb_d[S_JAL]   = 1'b1;
         end
         ST_JUMP: begin
            strb_d[S_GRA]  = 1'b1;
            strb_d[S_ROUT] = 1'b1;
            strb_d[S_PCEN] = 1'b1;
         end
         ST_DONE: begin
            strb_d[S_DONE] = 1'b1;
            // DONE straight from DECODE means the opcode was neither jr nor jal
            strb_d[S_UNSUP] = (state_q == ST_DECODE) && (ir_op != OP_NOP);
         end
         default: ;
      endcase
   end

   assign PCout_en    = strb_q[S_PCOUT];
   assign IncPC       = strb_q[S_INCPC];
   assign PC_en       = strb_q[S_PCEN];
   assign IR_en       = strb_q[S_IREN];
   assign MARin       = strb_q[S_MARIN];
   assign MDRin       = strb_q[S_MDRIN];
   assign MDRout      = strb_q[S_MDROUT];
   assign memRead     = strb_q[S_MEMRD];
   assign Zin         = strb_q[S_ZIN];
   assign Zlowout     = strb_q[S_ZLOW];
   assign Gra         = strb_q[S_GRA];
   assign Rin         = strb_q[S_RIN];
   assign Rout        = strb_q[S_ROUT];
   assign jal_R15     = strb_q[S_JAL];
   assign busy        = strb_q[S_BUSY];
   assign instr_done  = strb_q[S_DONE];
   assign unsupported = strb_q[S_UNSUP];
   assign alu_op      = alu_q;
`ifdef SEQ_INPORT_PRELOAD_EN
   assign inPortOut   = strb_q[S_INPORT];
`endif

endmodule

// File: tb/tb_jump_control_sequencer.sv
// Randomized bench for jump_control_sequencer: per-cycle outputs against a step-list
// model of each instruction, plus directed reset, run-drop, latency and stream cases.
module tb_jump_control_sequencer;

   localparam int unsigned W   = 2;
   localparam logic [4:0]  JR  = 5'b10101;
   localparam logic [4:0]  JAL = 5'b10110;
   localparam logic [4:0]  NOP = 5'b11010;
   localparam logic [4:0]  ADD = 5'b00011;
`ifdef SEQ_INPORT_PRELOAD_EN
   localparam int          PRE = 1;
`else
   localparam int          PRE = 0;
`endif

   typedef struct packed {
      logic pcout, incpc, pc_en, ir_en, marin, mdrin, mdrout, memread, zin, zlowout;
      logic gra, rin, rout, jal, inport, busy, done, unsup;
      logic [4:0] alu;
   } vec_t;

   logic       clock = 1'b0;
   logic       clear, run;
   logic [4:0] ir_op;
   logic PCout_en, IncPC, PC_en, IR_en, MARin, MDRin, MDRout, memRead, Zin, Zlowout;
   logic Gra, Rin, Rout, jal_R15, busy, instr_done, unsupported, inPortOut;
   logic [4:0] alu_op;

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;
   vec_t exp_q[$];
   vec_t exp_v;

   jump_control_sequencer #(.MEM_WAIT(W)) dut (
      .clock(clock), .clear(clear), .run(run), .ir_op(ir_op),
      .PCout_en(PCout_en), .IncPC(IncPC), .PC_en(PC_en), .IR_en(IR_en), .MARin(MARin),
      .MDRin(MDRin), .MDRout(MDRout), .memRead(memRead), .Zin(Zin), .Zlowout(Zlowout),
      .Gra(Gra), .Rin(Rin), .Rout(Rout), .jal_R15(jal_R15), .alu_op(alu_op),
      .busy(busy), .instr_done(instr_done), .unsupported(unsupported)
`ifdef SEQ_INPORT_PRELOAD_EN
      , .inPortOut(inPortOut)
`endif
   );
`ifndef SEQ_INPORT_PRELOAD_EN
   assign inPortOut = 1'b0;
`endif

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got=0x%0h exp=0x%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic vec_t idle_v();
      vec_t v;
      v     = '0;
      v.alu = NOP;
      return v;
   endfunction

   function automatic vec_t busy_v();
      vec_t v;
      v      = idle_v();
      v.busy = 1'b1;
      return v;
   endfunction

   // One instruction as the list of strobe sets it must produce, one entry per cycle
   task automatic push_instr(input logic [4:0] op);
      vec_t v;
      v = busy_v(); v.pcout = 1; v.marin = 1; v.incpc = 1; v.zin = 1; v.alu = ADD;
      exp_q.push_back(v);
      v = busy_v(); v.zlowout = 1; v.pc_en = 1; v.memread = 1; v.mdrin = 1;
      exp_q.push_back(v);
      for (int i = 0; i < int'(W); i++) begin
         v = busy_v(); v.memread = 1; v.mdrin = 1;
         exp_q.push_back(v);
      end
      v = busy_v(); v.mdrout = 1; v.ir_en = 1;
      exp_q.push_back(v);
      exp_q.push_back(busy_v());
      if (op == JR || op == JAL) begin
`ifdef SEQ_INPORT_PRELOAD_EN
         v = busy_v(); v.gra = 1; v.rin = 1; v.inport = 1;
         exp_q.push_back(v);
`endif
         if (op == JAL) begin
            v = busy_v(); v.pcout = 1; v.rin = 1; v.jal = 1;
            exp_q.push_back(v);
         end
         v = busy_v(); v.gra = 1; v.rout = 1; v.pc_en = 1;
         exp_q.push_back(v);
      end
      v = busy_v(); v.done = 1; v.unsup = !(op == JR || op == JAL || op == NOP);
      exp_q.push_back(v);
   endtask

   // Reference model: a new instruction starts whenever the previous one is retired and run=1
   always @(posedge clock or negedge clear) begin
      if (!clear) begin
         exp_q.delete();
         exp_v = idle_v();
      end else begin
         if (exp_q.size() == 0 && run) push_instr(ir_op);
         exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : idle_v();
      end
   end

   function automatic vec_t got_v();
      vec_t g;
      g = {PCout_en, IncPC, PC_en, IR_en, MARin, MDRin, MDRout, memRead, Zin, Zlowout,
           Gra, Rin, Rout, jal_R15, inPortOut, busy, instr_done, unsupported, alu_op};
      return g;
   endfunction

   task automatic tick();
      vec_t g;
      @(negedge clock);
      cyc++;
      g = got_v();
      chk("outputs", 32'(g), 32'(exp_v));
      chk("bus_excl", 32'($countones({g.pcout, g.zlowout, g.mdrout, g.rout}) > 1), 32'd0);
      chk("rin_pcen", 32'(g.rin & g.pc_en), 32'd0);
   endtask

   task automatic go_idle();
      bit ok;
      ok  = 0;
      run = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (exp_q.size() == 0 && !exp_v.busy) begin ok = 1; break; end
         tick();
      end
      if (!ok) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic lat_test(input logic [4:0] op, input int lat);
      int t0;
      bit seen;
      go_idle();
      ir_op = op;
      run   = 1'b1;
      t0    = -1;
      seen  = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (t0 < 0 && busy) begin t0 = cyc; run = 1'b0; end
         if (instr_done) begin
            chk("latency", 32'(cyc - t0 + 1), 32'(lat));
            seen = 1;
            break;
         end
      end
      if (!seen) chk("latency_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      logic [4:0] ops [3];
      int         last, n;
      bit         hit;

      clear = 1'b0;
      run   = 1'b0;
      ir_op = NOP;
      exp_v = idle_v();
      tick();
      chk("reset_alu", 32'(alu_op), 32'(NOP));
      chk("reset_busy", 32'(busy), 32'd0);
      clear = 1'b1;
      tick();

      // Reset taken while waiting on memory abandons the instruction
      ir_op = JR;
      run   = 1'b1;
      hit   = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (exp_v.memread && !exp_v.pc_en) begin hit = 1; break; end
      end
      chk("reached_wait", 32'(hit), 32'd1);
      #2 clear = 1'b0;
      #1 chk("async_reset", 32'(got_v()), 32'(idle_v()));
      run = 1'b0;
      tick();
      clear = 1'b1;
      tick();
      tick();
      chk("post_reset_busy", 32'(busy), 32'd0);
      run = 1'b1;
      tick();
      chk("restart_t0", 32'(PCout_en & MARin & IncPC), 32'd1);
      go_idle();

      // run dropped during T1 still completes the instruction
      ir_op = NOP;
      run   = 1'b1;
      hit   = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (exp_v.pc_en && exp_v.memread) begin hit = 1; break; end
      end
      chk("reached_t1", 32'(hit), 32'd1);
      run = 1'b0;
      hit = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (instr_done) begin hit = 1; break; end
      end
      chk("drop_run_done", 32'(hit), 32'd1);
      tick();
      chk("drop_run_idle", 32'(busy), 32'd0);

      lat_test(NOP, 5 + int'(W));
      lat_test(JR, 6 + int'(W) + PRE);
      lat_test(JAL, 7 + int'(W) + PRE);

      // Back-to-back stream: nop, nop, unsupported
      go_idle();
      ops[0] = NOP; ops[1] = NOP; ops[2] = 5'b00001;
      ir_op = ops[0];
      run   = 1'b1;
      last  = 0;
      n     = 0;
      for (int k = 0; k < 60 && n < 3; k++) begin
         tick();
         if (instr_done) begin
            if (n > 0) chk("done_period", 32'(cyc - last), 32'(5 + int'(W)));
            chk("unsup_flag", 32'(unsupported), 32'(n == 2));
            last = cyc;
            n++;
            if (n < 3) ir_op = ops[n];
            else       run = 1'b0;
         end
      end
      chk("stream_count", 32'(n), 32'd3);

      // Random run/opcode/reset traffic
      for (int i = 0; i < 1500; i++) begin
         tick();
         clear = 1'b1;
         run   = ($urandom_range(0, 3) != 0);
         if (exp_q.size() == 0) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3: ir_op = JR;
               4, 5, 6:    ir_op = JAL;
               7:          ir_op = NOP;
               default:    ir_op = 5'($urandom());
            endcase
         end
         if ($urandom_range(0, 99) == 0) begin
            #2 clear = 1'b0;
            #1 chk("rand_async_reset", 32'(got_v()), 32'(idle_v()));
         end
      end
      clear = 1'b1;
      go_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
